// File: rtl/fft_ctrl_pkg.sv
// Shared constants for the FFT input-stream controller.
package fft_ctrl_pkg;

   localparam int         DEF_DATA_W    = 14;
   localparam int         PTS_W         = 11;
   localparam int         DEF_FFT_PTS   = 1024;
   localparam logic [1:0] SINK_ERR_NONE = 2'b00;

endpackage

// File: rtl/fft_frame_counter.sv
// Frame position counter; sop/eop are registered from the count on each advance.
module fft_frame_counter #(
   parameter int FFT_PTS = 1024
) (
   input  logic clk,
   input  logic reset_n,
   input  logic advance,
   output logic sop,
   output logic eop
);

   localparam int              CNT_W = $clog2(FFT_PTS);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(FFT_PTS - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sop_q, eop_q;

   always_comb begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
         sop_q <= 1'b0;
         eop_q <= 1'b0;
      end else if (advance) begin
         sop_q <= (cnt_q == '0);
         eop_q <= (cnt_q == LAST);
         cnt_q <= cnt_d;
      end
   end

   assign sop = sop_q;
   assign eop = eop_q;

endmodule

// File: rtl/fft_control.sv
// Streams free-running ADC samples into an Avalon-ST FFT sink in back-to-back frames.
// Define ADC_OFFSET_BIN_EN when the ADC delivers offset-binary samples.
module fft_control
   import fft_ctrl_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int FFT_PTS = DEF_FFT_PTS
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] insignal,
   input  logic              sink_ready,
   output logic              sink_valid,
   output logic              sink_sop,
   output logic              sink_eop,
   output logic [1:0]        sink_error,
   output logic              inverse,
   output logic [DATA_W-1:0] outreal,
   output logic [DATA_W-1:0] outimag,
   output logic [PTS_W-1:0]  fft_pts
);

   logic [DATA_W-1:0] outreal_q, sample_d;
   logic              sink_valid_q;
   logic              load;

   // Output register refills whenever it is empty or being consumed this edge.
   assign load = ~sink_valid_q | sink_ready;

`ifdef ADC_OFFSET_BIN_EN
   assign sample_d = {~insignal[DATA_W-1], insignal[DATA_W-2:0]};
`else
   assign sample_d = insignal;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         outreal_q    <= '0;
         sink_valid_q <= 1'b0;
      end else if (load) begin
         outreal_q    <= sample_d;
         sink_valid_q <= 1'b1;
      end
   end

   fft_frame_counter #(.FFT_PTS(FFT_PTS)) u_frame_counter (
      .clk     (clk),
      .reset_n (reset_n),
      .advance (load),
      .sop     (sink_sop),
      .eop     (sink_eop)
   );

   assign sink_valid = sink_valid_q;
   assign outreal    = outreal_q;
   assign outimag    = '0;
   assign sink_error = SINK_ERR_NONE;
   assign inverse    = 1'b0;
   assign fft_pts    = PTS_W'(FFT_PTS);

endmodule

// File: tb/tb_fft_control.sv
// Bench for fft_control: a 1024-point and an 8-point instance share one stimulus stream.
module tb_fft_control;

   localparam int DW = 14;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          sink_ready = 1'b0;
   logic [DW-1:0] insignal = '0;

   logic          a_valid, a_sop, a_eop, a_inv, b_valid, b_sop, b_eop, b_inv;
   logic [1:0]    a_err, b_err;
   logic [DW-1:0] a_real, a_imag, b_real, b_imag;
   logic [10:0]   a_pts, b_pts;

   fft_control #(.DATA_W(DW), .FFT_PTS(1024)) dut_a (
      .clk(clk), .reset_n(reset_n), .insignal(insignal), .sink_ready(sink_ready),
      .sink_valid(a_valid), .sink_sop(a_sop), .sink_eop(a_eop), .sink_error(a_err),
      .inverse(a_inv), .outreal(a_real), .outimag(a_imag), .fft_pts(a_pts));

   fft_control #(.DATA_W(DW), .FFT_PTS(8)) dut_b (
      .clk(clk), .reset_n(reset_n), .insignal(insignal), .sink_ready(sink_ready),
      .sink_valid(b_valid), .sink_sop(b_sop), .sink_eop(b_eop), .sink_error(b_err),
      .inverse(b_inv), .outreal(b_real), .outimag(b_imag), .fft_pts(b_pts));

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int npts[2] = '{1024, 8};
   // Model: whether a sample is on offer, its value, its frame index, next index to hand out.
   int m_vld[2], m_data[2], m_cur[2], m_next[2], xfer[2];
   int r = 0;

   // Offset-binary to two's complement is a shift by half the code range, modulo 2^DW.
   function automatic int conv(input int x);
`ifdef ADC_OFFSET_BIN_EN
      return (x + (1 << (DW - 1))) % (1 << DW);
`else
      return x;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_vld[k] = 0; m_data[k] = 0; m_cur[k] = -1; m_next[k] = 0;
      end
   endtask

   task automatic model_edge();
      for (int k = 0; k < 2; k++) begin
         if (m_vld[k] == 0 || sink_ready) begin
            m_data[k] = conv(int'(insignal));
            m_cur[k]  = m_next[k];
            m_next[k] = (m_next[k] + 1) % npts[k];
            m_vld[k]  = 1;
         end
      end
   endtask

   task automatic check_all();
      chk("a_valid", a_valid, m_vld[0]);
      chk("a_outreal", a_real, m_data[0]);
      chk("a_sop", a_sop, (m_vld[0] != 0 && m_cur[0] == 0));
      chk("a_eop", a_eop, (m_vld[0] != 0 && m_cur[0] == npts[0] - 1));
      chk("a_fft_pts", a_pts, 1024);
      chk("a_const", {a_inv, a_err, a_imag}, 0);
      chk("b_valid", b_valid, m_vld[1]);
      chk("b_outreal", b_real, m_data[1]);
      chk("b_sop", b_sop, (m_vld[1] != 0 && m_cur[1] == 0));
      chk("b_eop", b_eop, (m_vld[1] != 0 && m_cur[1] == npts[1] - 1));
      chk("b_fft_pts", b_pts, 8);
      chk("b_const", {b_inv, b_err, b_imag}, 0);
   endtask

   // Frame length is counted on observed transfers, independent of the model.
   task automatic account();
      if (a_valid && sink_ready) begin
         xfer[0] = a_sop ? 1 : xfer[0] + 1;
         if (a_eop) chk("a_frame_len", xfer[0], npts[0]);
      end
      if (b_valid && sink_ready) begin
         xfer[1] = b_sop ? 1 : xfer[1] + 1;
         if (b_eop) chk("b_frame_len", xfer[1], npts[1]);
      end
   endtask

   task automatic step();
      account();
      @(posedge clk);
      if (reset_n) model_edge(); else model_reset();
      #1;
      check_all();
   endtask

   task automatic ramp_step();
      insignal = DW'(r);
      r++;
      step();
   endtask

   initial begin
      int guard;
      model_reset();
      xfer[0] = 0; xfer[1] = 0;
      step();
      step();

      // Ramp with ready held high; first loaded sample carries sop.
      @(negedge clk);
      reset_n = 1'b1;
      sink_ready = 1'b1;
      ramp_step();
      chk("first_sop", a_sop, 1);
      chk("first_outreal", a_real, conv(0));
      for (int i = 0; i < 1027; i++) ramp_step();

      // Stall for 5 cycles while frame sample 100 is on offer.
      guard = 0;
      while (m_cur[0] != 100 && guard < 2000) begin ramp_step(); guard++; end
      chk("reach_100", m_cur[0], 100);
      sink_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         ramp_step();
         chk("stall_hold", a_real, conv(100 + 1028 - 1024 + 0) == 0 ? a_real : m_data[0]);
      end
      sink_ready = 1'b1;
      ramp_step();
      chk("after_stall_idx", m_cur[0], 101);

      // Mid-frame reset at sample 500, held for 3 cycles.
      guard = 0;
      while (m_cur[0] != 500 && guard < 2000) begin ramp_step(); guard++; end
      chk("reach_500", m_cur[0], 500);
      reset_n = 1'b0;
      model_reset();
      #1;
      check_all();
      for (int i = 0; i < 3; i++) ramp_step();
      @(negedge clk);
      reset_n = 1'b1;
      ramp_step();
      chk("post_reset_sop", a_sop, 1);
      for (int i = 0; i < 1030; i++) ramp_step();

      // Random samples with random backpressure.
      for (int i = 0; i < 1500; i++) begin
         insignal   = DW'($urandom);
         sink_ready = ($urandom_range(0, 3) != 0);
         step();
      end

      // Sign-bit handling at the code-range boundaries.
      sink_ready = 1'b1;
      insignal = 14'h2000;
      step();
      chk("conv_2000", a_real, conv(32'h2000));
      insignal = 14'h0000;
      step();
      chk("conv_0000", a_real, conv(0));
      insignal = 14'h3fff;
      step();
      chk("conv_3fff", b_real, conv(32'h3fff));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fft_control.md
FFT_CONTROL -- requirements
Module: fft_control

Interface
- REQ-001 SHALL have parameter DATA_W, default 14: sample width of insignal, outreal and outimag.
- REQ-002 SHALL have parameter FFT_PTS, default 1024: frame length; legal values are powers of two, 8..1024.
- REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic rising-edge.
- REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
- REQ-005 SHALL have port insignal, input, DATA_W bits: free-running ADC sample, one per clock.
- REQ-006 SHALL have port sink_ready, input, 1 bit: FFT core ready (Avalon-ST, readyLatency 0).
- REQ-007 SHALL have port sink_valid, output, 1 bit: sample valid toward the FFT core.
- REQ-008 SHALL have port sink_sop, output, 1 bit: first sample of frame.
- REQ-009 SHALL have port sink_eop, output, 1 bit: last sample of frame.
- REQ-010 SHALL have port sink_error, output, 2 bits: stream error; constant 2'b00.
- REQ-011 SHALL have port inverse, output, 1 bit: transform direction; constant 0 (forward FFT).
- REQ-012 SHALL have port outreal, output, DATA_W bits: real sample to the FFT core.
- REQ-013 SHALL have port outimag, output, DATA_W bits: imaginary sample; constant 0.
- REQ-014 SHALL have port fft_pts, output, 11 bits: frame length; constant FFT_PTS.

Function
- REQ-015 SHALL define a transfer as a rising edge with sink_valid=1 and sink_ready=1.
- REQ-016 SHALL treat an edge with sink_valid=0 or sink_ready=1 as a load edge (registered output stage).
- On a load edge, outreal SHALL take insignal (converted per REQ-025 when enabled) and sink_valid SHALL go to 1.
- REQ-017 SHALL keep a frame counter cnt in the range 0..FFT_PTS-1, initialised to 0.
- On a load edge, sink_sop SHALL be (cnt==0) and sink_eop SHALL be (cnt==FFT_PTS-1).
- On a load edge, cnt SHALL increment, wrapping from FFT_PTS-1 to 0.
- REQ-018 SHALL, on stall (sink_valid=1, sink_ready=0), hold outreal, sink_sop, sink_eop, sink_valid and cnt unchanged; samples arriving during a stall are dropped.
- REQ-019 SHALL deassert sink_valid only in reset; after the first load it remains 1.
- REQ-020 SHALL make sink_sop and sink_eop one transfer wide each; exactly FFT_PTS transfers lie from sop to eop inclusive.
- REQ-021 SHALL start frames back-to-back: the next load after an eop transfer carries sop.
- REQ-022 SHALL have a latency of 1 clock from insignal to outreal when sink_ready is held high.
- REQ-023 SHALL drive fft_pts, inverse, sink_error and outimag combinationally from constants, independent of reset.

Reset
- REQ-024 SHALL, while reset_n=0, force sink_valid=0, sink_sop=0, sink_eop=0, outreal=0 and cnt=0.
- The first load edge after release SHALL present frame sample 0 with sink_sop=1.
- Reset asserted mid-frame SHALL abandon the partial frame; no eop is generated for it.

Configuration
- REQ-025 SHALL support macro ADC_OFFSET_BIN_EN.
  - Defined: insignal is offset-binary; invert its MSB before loading outreal (two's complement out).
  - Undefined: insignal passes unchanged (already two's complement).

Structure
- REQ-026 SHALL place DATA_W default, PTS_W=11, default FFT_PTS and the SINK_ERR_NONE=2'b00 constant in package fft_ctrl_pkg.
- REQ-027 SHALL implement cnt plus its sop/eop decode in sub-module fft_frame_counter, with ports clk, reset_n, advance, sop, eop.

Verification
- REQ-028 Reset then sink_ready=1, insignal=ramp 0,1,2... -> first valid cycle outreal=0 with sop=1; outreal=1023 with eop=1; next sample has sop=1 again.
- REQ-029 sink_ready=0 for 5 cycles at frame sample 100 -> outreal, sop/eop and cnt frozen; after release, the next accepted index is 101; frame still has exactly 1024 transfers.
- REQ-030 Reset asserted at sample 500, released 3 cycles later -> all outputs 0 during reset; new frame starts with sop=1 and eop after 1024 transfers.
- REQ-031 ADC_OFFSET_BIN_EN defined, insignal=14'h2000 -> outreal=14'h0000; insignal=14'h0000 -> outreal=14'h2000; undefined -> outreal equals insignal.
- REQ-032 FFT_PTS=8 -> fft_pts=11'd8; sop/eop period is 8 transfers; inverse=0, sink_error=0 and outimag=0 throughout.
